// File: rtl/pong_state_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : pong_state_frame_tx
// Purpose  : Snapshots the Pong game state on request and streams an 8-byte
//            frame (header, 6 payload bytes, XOR checksum) to a byte UART
//            transmitter over its DV/Done handshake, guarded by a per-byte
//            watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module pong_state_frame_tx #(
   parameter logic [7:0] HEADER_BYTE    = 8'hA5,
   parameter int         GAP_CYCLES     = 0,
   parameter int         TIMEOUT_CYCLES = 4096
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_Send,
   input  logic [3:0] i_Score_P1,
   input  logic [3:0] i_Score_P2,
   input  logic [5:0] i_Paddle_Y_P1,
   input  logic [5:0] i_Paddle_Y_P2,
   input  logic [5:0] i_Ball_X,
   input  logic [5:0] i_Ball_Y,
   input  logic       i_TX_Done,
   output logic       o_TX_DV,
   output logic [7:0] o_TX_Byte,
   output logic       o_Busy,
   output logic       o_Frame_Done,
   output logic       o_Error,
   output logic       o_Send_Dropped
);

   // Counter widths; a 1-bit floor keeps degenerate parameter values legal.
   localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int c_WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [c_GAP_W-1:0] c_GAP_LAST = (GAP_CYCLES > 0) ? c_GAP_W'(GAP_CYCLES - 1) : '0;
   localparam logic [c_WD_W-1:0]  c_WD_LAST  = c_WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_WAIT_DONE = 3'd2,
      S_GAP       = 3'd3,
      S_FINISH    = 3'd4,
      S_ABORT     = 3'd5
   } state_t;

   state_t             r_state;
   logic [2:0]         r_idx;
   logic [c_GAP_W-1:0] r_gap;
   logic [c_WD_W-1:0]  r_wd;
   logic [7:0]         r_frame [8];

   logic               r_TX_DV;
   logic [7:0]         r_TX_Byte;
   logic               r_Busy;
   logic               r_Frame_Done;
   logic               r_Error;
   logic               r_Send_Dropped;

   logic [7:0]         w_csum;
   logic [2:0]         w_idx_nxt;
   logic [c_WD_W-1:0]  w_wd_inc;

   // Checksum over the live payload; captured together with the payload.
   always_comb begin
      w_csum    = {4'b0, i_Score_P1} ^ {4'b0, i_Score_P2} ^
                  {2'b0, i_Paddle_Y_P1} ^ {2'b0, i_Paddle_Y_P2} ^
                  {2'b0, i_Ball_X} ^ {2'b0, i_Ball_Y};
      w_idx_nxt = r_idx + 3'd1;
      w_wd_inc  = r_wd + 1'b1;
   end

   // Frame sequencer: snapshot, issue each byte, wait for Done, optional gap.
   // All outputs are registered and asserted on the transition into the
   // state that owns them, so each pulse lines up with its state cycle.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_state        <= S_IDLE;
         r_idx          <= '0;
         r_gap          <= '0;
         r_wd           <= '0;
         for (int i = 0; i < 8; i++) r_frame[i] <= '0;
         r_TX_DV        <= 1'b0;
         r_TX_Byte      <= 8'h00;
         r_Busy         <= 1'b0;
         r_Frame_Done   <= 1'b0;
         r_Error        <= 1'b0;
         r_Send_Dropped <= 1'b0;
      end else begin
         r_TX_DV        <= 1'b0;
         r_Frame_Done   <= 1'b0;
         r_Error        <= 1'b0;
         // Requests outside IDLE are reported and discarded, never queued.
         r_Send_Dropped <= i_Send && (r_state != S_IDLE);

         case (r_state)
            S_IDLE: begin
               if (i_Send) begin
                  r_frame[0] <= HEADER_BYTE;
                  r_frame[1] <= {4'b0, i_Score_P1};
                  r_frame[2] <= {4'b0, i_Score_P2};
                  r_frame[3] <= {2'b0, i_Paddle_Y_P1};
                  r_frame[4] <= {2'b0, i_Paddle_Y_P2};
                  r_frame[5] <= {2'b0, i_Ball_X};
                  r_frame[6] <= {2'b0, i_Ball_Y};
                  r_frame[7] <= w_csum;
                  r_idx      <= 3'd0;
                  r_TX_DV    <= 1'b1;
                  r_TX_Byte  <= HEADER_BYTE;
                  r_Busy     <= 1'b1;
                  r_state    <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               r_wd    <= '0;
               r_state <= S_WAIT_DONE;
            end

            S_WAIT_DONE: begin
               // Done takes priority over a coincident watchdog expiry.
               if (i_TX_Done) begin
                  if (r_idx == 3'd7) begin
                     r_Frame_Done <= 1'b1;
                     r_state      <= S_FINISH;
                  end else begin
                     r_idx <= w_idx_nxt;
                     if (GAP_CYCLES > 0) begin
                        r_gap   <= '0;
                        r_state <= S_GAP;
                     end else begin
                        r_TX_DV   <= 1'b1;
                        r_TX_Byte <= r_frame[w_idx_nxt];
                        r_state   <= S_ISSUE;
                     end
                  end
               end else if (w_wd_inc == c_WD_LAST) begin
                  r_wd    <= w_wd_inc;
                  r_Error <= 1'b1;
                  r_state <= S_ABORT;
               end else begin
                  r_wd <= w_wd_inc;
               end
            end

            S_GAP: begin
               if (r_gap == c_GAP_LAST) begin
                  r_TX_DV   <= 1'b1;
                  r_TX_Byte <= r_frame[r_idx];
                  r_state   <= S_ISSUE;
               end else begin
                  r_gap <= r_gap + 1'b1;
               end
            end

            S_FINISH, S_ABORT: begin
               r_Busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_Busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_TX_DV        = r_TX_DV;
   assign o_TX_Byte      = r_TX_Byte;
   assign o_Busy         = r_Busy;
   assign o_Frame_Done   = r_Frame_Done;
   assign o_Error        = r_Error;
   assign o_Send_Dropped = r_Send_Dropped;

endmodule
`default_nettype wire

// File: tb/tb_pong_state_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_state_frame_tx
// Purpose  : Directed self-checking bench for pong_state_frame_tx. Instance 0
//            runs back-to-back bytes, instance 1 inserts a 3-cycle gap; both
//            use a 64-cycle watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pong_state_frame_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       send0, send1, done0, done1;
   logic [3:0] s1, s2;
   logic [5:0] p1, p2, bx, by;

   logic       dv0, busy0, fd0, err0, drop0;
   logic [7:0] byte0;
   logic       dv1, busy1, fd1, err1, drop1;
   logic [7:0] byte1;

   int total = 0;
   int bad   = 0;
   int sel   = 0;

   wire       m_dv   = (sel != 0) ? dv1   : dv0;
   wire [7:0] m_byte = (sel != 0) ? byte1 : byte0;
   wire       m_busy = (sel != 0) ? busy1 : busy0;
   wire       m_fd   = (sel != 0) ? fd1   : fd0;
   wire       m_err  = (sel != 0) ? err1  : err0;
   wire       m_drop = (sel != 0) ? drop1 : drop0;

   pong_state_frame_tx #(.HEADER_BYTE(8'hA5), .GAP_CYCLES(0), .TIMEOUT_CYCLES(64)) u_dut0 (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Send(send0),
      .i_Score_P1(s1), .i_Score_P2(s2), .i_Paddle_Y_P1(p1), .i_Paddle_Y_P2(p2),
      .i_Ball_X(bx), .i_Ball_Y(by), .i_TX_Done(done0),
      .o_TX_DV(dv0), .o_TX_Byte(byte0), .o_Busy(busy0),
      .o_Frame_Done(fd0), .o_Error(err0), .o_Send_Dropped(drop0));

   pong_state_frame_tx #(.HEADER_BYTE(8'hA5), .GAP_CYCLES(3), .TIMEOUT_CYCLES(64)) u_dut1 (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Send(send1),
      .i_Score_P1(s1), .i_Score_P2(s2), .i_Paddle_Y_P1(p1), .i_Paddle_Y_P2(p2),
      .i_Ball_X(bx), .i_Ball_Y(by), .i_TX_Done(done1),
      .o_TX_DV(dv1), .o_TX_Byte(byte1), .o_Busy(busy1),
      .o_Frame_Done(fd1), .o_Error(err1), .o_Send_Dropped(drop1));

   // Results of the most recent run_frame call.
   logic [7:0] rf_bytes [8];
   int rf_ndv, rf_nfd, rf_nerr, rf_ndrop, rf_unstable, rf_err_lat;
   int rf_dmin, rf_dmax, rf_first_dv_t;
   bit rf_timeout, rf_busy1;

   task automatic set_inputs(input logic [3:0] a, input logic [3:0] b, input logic [5:0] c,
                             input logic [5:0] d, input logic [5:0] e, input logic [5:0] f);
      s1 = a; s2 = b; p1 = c; p2 = d; bx = e; by = f;
   endtask

   task automatic pulse_send();
      @(negedge clk);
      if (sel != 0) send1 = 1'b1; else send0 = 1'b1;
   endtask

   // Transmitter model: answers each DV with Done 'delay' cycles later,
   // optionally stalls one byte, injects a request, or asserts reset.
   task automatic run_frame(input int delay, input int stall_idx, input int drop_idx,
                            input int rst_idx, input bit scramble);
      int t = 0, cnt = -1, last_done = -1, last_dv = -1, tail = -1, d;
      bit in_wait = 0, fin = 0;
      logic [7:0] held = 8'h00;
      rf_ndv = 0; rf_nfd = 0; rf_nerr = 0; rf_ndrop = 0; rf_unstable = 0;
      rf_err_lat = -1; rf_dmin = 1000; rf_dmax = -1; rf_first_dv_t = -1; rf_busy1 = 0;
      for (int i = 0; i < 8; i++) rf_bytes[i] = 8'hxx;
      while (!fin && t < 2000) begin
         @(negedge clk);
         t++;
         if (m_dv === 1'b1) begin
            if (rf_first_dv_t < 0) rf_first_dv_t = t;
            if (rf_ndv < 8) rf_bytes[rf_ndv] = m_byte;
            if (last_done >= 0) begin
               d = t - last_done;
               if (d < rf_dmin) rf_dmin = d;
               if (d > rf_dmax) rf_dmax = d;
            end
            last_dv = t; held = m_byte; in_wait = 1;
            cnt = (rf_ndv == stall_idx) ? -1 : delay;
            rf_ndv++;
         end else if (in_wait && m_byte !== held) begin
            rf_unstable++;
         end
         if (t == 1) rf_busy1 = m_busy;
         if (m_fd === 1'b1) begin rf_nfd++; if (tail < 0) tail = 30; end
         if (m_err === 1'b1) begin
            rf_nerr++; rf_err_lat = t - last_dv; in_wait = 0;
            if (tail < 0) tail = 30;
         end
         if (m_drop === 1'b1) rf_ndrop++;

         done0 = 0; done1 = 0; send0 = 0; send1 = 0;
         if (t == 1 && scramble) set_inputs(4'hF, 4'hE, 6'h3E, 6'h3D, 6'h11, 6'h22);
         if (cnt > 0 && last_dv != t) begin
            cnt--;
            if (cnt == 0) begin
               if (sel != 0) done1 = 1; else done0 = 1;
               last_done = t; in_wait = 0; cnt = -1;
            end
         end
         if (drop_idx >= 0 && rf_ndv == drop_idx + 1 && t == last_dv + 5) begin
            if (sel != 0) send1 = 1; else send0 = 1;
         end
         if (rst_idx >= 0 && rf_ndv == rst_idx + 1 && t == last_dv + 3) begin
            rst_n = 1'b0; fin = 1;
         end
         if (tail > 0) begin tail--; if (tail == 0) fin = 1; end
      end
      rf_timeout = !fin;
   endtask

   task automatic test_reset();
      sel = 0;
      repeat (3) @(negedge clk);
      total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy0); end
      total++; if (dv0 !== 1'b0) begin bad++; $display("FAIL reset_dv got=%b want=0", dv0); end
      total++; if (byte0 !== 8'h00) begin bad++; $display("FAIL reset_byte got=%h want=00", byte0); end
      total++; if ({fd0, err0, drop0} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b want=000", {fd0, err0, drop0}); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_frame();
      logic [7:0] exp_b [8] = '{8'hA5, 8'h03, 8'h05, 8'h0A, 8'h14, 8'h20, 8'h0F, 8'h37};
      sel = 0;
      set_inputs(4'd3, 4'd5, 6'd10, 6'd20, 6'd32, 6'd15);
      pulse_send();
      run_frame(20, -1, -1, -1, 0);
      total++; if (rf_timeout) begin bad++; $display("FAIL frame_timeout got=1 want=0"); end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (rf_bytes[i] !== exp_b[i]) begin bad++; $display("FAIL frame_byte%0d got=%h want=%h", i, rf_bytes[i], exp_b[i]); end
      end
      total++; if (rf_ndv != 8) begin bad++; $display("FAIL frame_dv_count got=%0d want=8", rf_ndv); end
      total++; if (rf_nfd != 1) begin bad++; $display("FAIL frame_done_count got=%0d want=1", rf_nfd); end
      total++; if (rf_nerr != 0) begin bad++; $display("FAIL frame_err_count got=%0d want=0", rf_nerr); end
      total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL frame_busy_end got=%b want=0", busy0); end
   endtask

   task automatic test_latency_snapshot();
      logic [7:0] exp_b [8] = '{8'hA5, 8'h09, 8'h02, 8'h21, 8'h01, 8'h3F, 8'h00, 8'h14};
      sel = 0;
      set_inputs(4'd9, 4'd2, 6'd33, 6'd1, 6'd63, 6'd0);
      pulse_send();
      total++; if ({dv0, busy0} !== 2'b00) begin bad++; $display("FAIL lat_pre_edge got=%b want=00", {dv0, busy0}); end
      run_frame(5, -1, -1, -1, 1);
      total++; if (rf_first_dv_t != 1) begin bad++; $display("FAIL lat_dv_cycle got=%0d want=1", rf_first_dv_t); end
      total++; if (rf_busy1 !== 1'b1) begin bad++; $display("FAIL lat_busy got=%b want=1", rf_busy1); end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (rf_bytes[i] !== exp_b[i]) begin bad++; $display("FAIL snap_byte%0d got=%h want=%h", i, rf_bytes[i], exp_b[i]); end
      end
      total++; if (rf_nfd != 1) begin bad++; $display("FAIL snap_done_count got=%0d want=1", rf_nfd); end
   endtask

   task automatic test_gap();
      sel = 1;
      set_inputs(4'd3, 4'd5, 6'd10, 6'd20, 6'd32, 6'd15);
      pulse_send();
      run_frame(7, -1, -1, -1, 0);
      total++; if (rf_ndv != 8) begin bad++; $display("FAIL gap_dv_count got=%0d want=8", rf_ndv); end
      total++; if (rf_dmin != 4 || rf_dmax != 4) begin bad++; $display("FAIL gap_spacing got=%0d..%0d want=4..4", rf_dmin, rf_dmax); end
      total++; if (rf_unstable != 0) begin bad++; $display("FAIL gap_byte_stable got=%0d want=0", rf_unstable); end
      total++; if (rf_bytes[7] !== 8'h37) begin bad++; $display("FAIL gap_checksum got=%h want=37", rf_bytes[7]); end
      total++; if (rf_nfd != 1) begin bad++; $display("FAIL gap_done_count got=%0d want=1", rf_nfd); end
      sel = 0;
   endtask

   task automatic test_timeout();
      logic [7:0] exp_b [8] = '{8'hA5, 8'h03, 8'h05, 8'h0A, 8'h14, 8'h20, 8'h0F, 8'h37};
      sel = 0;
      set_inputs(4'd3, 4'd5, 6'd10, 6'd20, 6'd32, 6'd15);
      pulse_send();
      run_frame(10, 2, -1, -1, 0);
      total++; if (rf_nerr != 1) begin bad++; $display("FAIL to_err_count got=%0d want=1", rf_nerr); end
      total++; if (rf_err_lat != 64) begin bad++; $display("FAIL to_err_latency got=%0d want=64", rf_err_lat); end
      total++; if (rf_ndv != 3) begin bad++; $display("FAIL to_dv_count got=%0d want=3", rf_ndv); end
      total++; if (rf_nfd != 0) begin bad++; $display("FAIL to_done_count got=%0d want=0", rf_nfd); end
      total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL to_busy_idle got=%b want=0", busy0); end
      pulse_send();
      run_frame(10, -1, -1, -1, 0);
      for (int i = 0; i < 8; i++) begin
         total++;
         if (rf_bytes[i] !== exp_b[i]) begin bad++; $display("FAIL to_fresh_byte%0d got=%h want=%h", i, rf_bytes[i], exp_b[i]); end
      end
      total++; if (rf_nfd != 1) begin bad++; $display("FAIL to_fresh_done got=%0d want=1", rf_nfd); end
   endtask

   task automatic test_send_dropped();
      sel = 0;
      set_inputs(4'd3, 4'd5, 6'd10, 6'd20, 6'd32, 6'd15);
      pulse_send();
      run_frame(20, -1, 4, -1, 0);
      total++; if (rf_ndrop != 1) begin bad++; $display("FAIL drop_count got=%0d want=1", rf_ndrop); end
      total++; if (rf_ndv != 8) begin bad++; $display("FAIL drop_dv_count got=%0d want=8", rf_ndv); end
      total++; if (rf_nfd != 1) begin bad++; $display("FAIL drop_done_count got=%0d want=1", rf_nfd); end
      total++; if (rf_bytes[4] !== 8'h14 || rf_bytes[7] !== 8'h37) begin
         bad++; $display("FAIL drop_bytes got=%h/%h want=14/37", rf_bytes[4], rf_bytes[7]);
      end
   endtask

   task automatic test_reset_mid_frame();
      int ndv = 0, nfd = 0, nbusy = 0;
      sel = 0;
      set_inputs(4'd3, 4'd5, 6'd10, 6'd20, 6'd32, 6'd15);
      pulse_send();
      run_frame(20, -1, -1, 5, 0);
      #1;
      total++; if (rf_ndv != 6) begin bad++; $display("FAIL rst_mid_dv_count got=%0d want=6", rf_ndv); end
      total++; if ({dv0, busy0, fd0, err0, drop0} !== 5'b0) begin
         bad++; $display("FAIL rst_mid_outputs got=%b want=00000", {dv0, busy0, fd0, err0, drop0});
      end
      total++; if (byte0 !== 8'h00) begin bad++; $display("FAIL rst_mid_byte got=%h want=00", byte0); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); done0 = 1'b1;
      @(negedge clk); done0 = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (dv0 === 1'b1) ndv++;
         if (fd0 === 1'b1) nfd++;
         if (busy0 === 1'b1) nbusy++;
      end
      total++; if (ndv != 0) begin bad++; $display("FAIL stray_done_dv got=%0d want=0", ndv); end
      total++; if (nfd != 0) begin bad++; $display("FAIL stray_done_fd got=%0d want=0", nfd); end
      total++; if (nbusy != 0) begin bad++; $display("FAIL stray_done_busy got=%0d want=0", nbusy); end
   endtask

   initial begin
      rst_n = 1'b0;
      send0 = 0; send1 = 0; done0 = 0; done1 = 0;
      set_inputs(4'd0, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0);
      test_reset();
      test_frame();
      test_latency_snapshot();
      test_gap();
      test_timeout();
      test_send_dropped();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pong_state_frame_tx.md
Name: pong_state_frame_tx

Overview:
- Upstream feeder for the byte-level UART transmitter in the Pong full-game design.
- On a send request, snapshots the live game state (scores, paddle rows, ball position) and builds an 8-byte frame: header, 6 payload bytes, XOR checksum.
- Issues the frame one byte at a time over the transmitter's DV/Done handshake, with a per-byte watchdog against a stalled transmitter.

Parameters:
- HEADER_BYTE, 8'hA5, constant first byte of every frame.
- GAP_CYCLES, 0, idle clocks inserted between bytes (0 = back-to-back).
- TIMEOUT_CYCLES, 4096, max clocks to wait for i_TX_Done per byte before aborting; must exceed 10 × BIT_PERIOD of the transmitter.

Ports:
- i_Clk  in  1  system clock.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_Send  in  1  frame request, sampled only in IDLE.
- i_Score_P1  in  4  player 1 score.
- i_Score_P2  in  4  player 2 score.
- i_Paddle_Y_P1  in  6  player 1 paddle top row.
- i_Paddle_Y_P2  in  6  player 2 paddle top row.
- i_Ball_X  in  6  ball column.
- i_Ball_Y  in  6  ball row.
- i_TX_Done  in  1  one-cycle pulse from transmitter: byte fully sent.
- o_TX_DV  out  1  one-cycle byte-valid strobe to transmitter.
- o_TX_Byte  out  8  byte to transmit.
- o_Busy  out  1  high from snapshot until return to IDLE.
- o_Frame_Done  out  1  one-cycle pulse, frame complete.
- o_Error  out  1  one-cycle pulse, watchdog abort.
- o_Send_Dropped  out  1  one-cycle pulse, i_Send seen while busy.

Behaviour:
- Reset (async assert, sync release): state IDLE; every output 0, including o_TX_Byte = 8'h00; byte index, gap counter, watchdog counter and snapshot registers cleared.
- Frame order (idx 0..7): HEADER_BYTE, {4'b0,Score_P1}, {4'b0,Score_P2}, {2'b0,Paddle_Y_P1}, {2'b0,Paddle_Y_P2}, {2'b0,Ball_X}, {2'b0,Ball_Y}, checksum.
- Checksum = XOR of bytes 1..6. The header is excluded.
- Snapshot: all state inputs and the checksum are registered on the edge where IDLE samples i_Send=1. Input changes after that edge do not affect the frame.
- States: IDLE, ISSUE, WAIT_DONE, GAP, FINISH, ABORT.
- IDLE:
  - i_Send=1 → take snapshot, idx=0, go to ISSUE.
  - Latency: i_Send high at edge k gives o_TX_DV high during cycle k+1.
- ISSUE:
  - o_TX_DV=1 for exactly one cycle; o_TX_Byte = frame[idx]; watchdog = 0.
  - Go to WAIT_DONE.
- WAIT_DONE:
  - o_TX_DV=0. o_TX_Byte is held stable, because the transmitter captures the byte the cycle after DV.
  - Watchdog increments each cycle.
  - i_TX_Done=1 and idx=7 → FINISH.
  - i_TX_Done=1 and idx<7 → idx+1, then GAP if GAP_CYCLES>0, otherwise ISSUE.
  - Watchdog reaches TIMEOUT_CYCLES-1 without i_TX_Done → ABORT.
  - If i_TX_Done and the timeout coincide, Done wins.
- GAP: counts GAP_CYCLES clocks, then goes to ISSUE.
- FINISH: o_Frame_Done=1 for one cycle → IDLE.
- ABORT: o_Error=1 for one cycle → IDLE. The partial frame is abandoned; no retry.
- o_Busy = 1 in every state except IDLE.
- o_Send_Dropped pulses for each cycle i_Send=1 while not in IDLE. Dropped requests are not queued.
- i_TX_Done in IDLE, ISSUE or GAP is ignored, including a stale Done after a reset or abort.
- Reset mid-frame: immediate return to IDLE with DV low. The transmitter may still finish its current byte; that is acceptable.
- All counters are sized with $clog2 of their parameter and do not wrap within normal operation.

Test Plan:
- Scores 3/5, paddles 10/20, ball (32,15), pulse i_Send, Done 20 cycles after each DV → bytes A5 03 05 0A 14 20 0F 37, exactly 8 DV pulses, one o_Frame_Done after the 8th Done.
- i_Send at edge k → o_TX_DV high in cycle k+1, o_Busy high from k+1. Change all inputs right after the snapshot → transmitted bytes unchanged.
- GAP_CYCLES=3 → each DV occurs exactly 4 cycles after the preceding i_TX_Done; o_TX_Byte stable throughout WAIT_DONE.
- Withhold i_TX_Done after byte 2 with TIMEOUT_CYCLES=64 → o_Error pulses 64 cycles after that DV; return to IDLE; a later i_Send starts a fresh frame at A5.
- Pulse i_Send during byte 4 → o_Send_Dropped pulses once, frame completes unaltered, no second frame.
- Drop i_Rst_L mid-byte 5, then deliver a stray i_TX_Done in IDLE → all outputs 0, no DV, no Frame_Done.
